// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the configuration scan-chain side blocks.
//   - FSM state encoding of the bitstream serializer
//   - sc_clog2: constant ceil(log2(v)) used to size counters
// ---------------------------------------------------------------------------
package sc_pkg;

  typedef logic [2:0] sc_state_t;

  localparam sc_state_t ST_IDLE  = 3'd0;
  localparam sc_state_t ST_CLEAR = 3'd1;
  localparam sc_state_t ST_LOAD  = 3'd2;
  localparam sc_state_t ST_SHIFT = 3'd3;
  localparam sc_state_t ST_DONE  = 3'd4;

  // ceil(log2(v)); returns 0 for v <= 1.
  function automatic int sc_clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_piso_word.sv
// ---------------------------------------------------------------------------
// sc_piso_word
// One configuration word, parallel in / serial out, LSB first.
//   clk, rst   : clock, async active-high reset
//   load_i     : capture word_i and restart the bit counter
//   shift_i    : shift right by one and advance the bit counter
//   word_i     : parallel word
//   bit_o      : current serial bit (shreg[0])
//   last_o     : the current bit is the word's MSB
// ---------------------------------------------------------------------------
module sc_piso_word
  import sc_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic                  bit_o,
  output logic                  last_o
);

  localparam int BIT_CNT_W = sc_clog2(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] r_shreg;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;

  // A load in the same cycle as a shift wins: the outgoing bit is the last
  // one of the old word and the new word starts at bit 0 next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (load_i) begin
      r_shreg   <= word_i;
      r_bit_cnt <= '0;
    end else if (shift_i) begin
      r_shreg   <= r_shreg >> 1;
      r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
    end
  end

  assign bit_o  = r_shreg[0];
  assign last_o = (r_bit_cnt == BIT_CNT_W'(WORD_WIDTH - 1));

endmodule

// File: rtl/sc_bitstream_serializer.sv
// ---------------------------------------------------------------------------
// sc_bitstream_serializer
// Feeds the core's configuration scan chain from the bitstream word stream.
// A load clears the chain for one cycle, then shifts exactly SC_LENGTH bits,
// LSB of each word first, one bit per clk.
//   clk, rst       : clock shared with the chain, async active-high reset
//   start_i        : one-cycle load request (ignored and flagged when busy)
//   abort_i        : drop the current load, back to idle
//   word_i/valid_i : configuration word, valid/ready handshake
//   word_ready_o   : word accepted this cycle when valid
//   sc_en_o        : chain shift enable
//   sc_data_o      : chain serial data
//   sc_clear_o     : chain clear, active-low
//   busy_o         : not idle
//   done_o         : one-cycle pulse after the last bit
//   err_o          : one-cycle pulse after a start_i seen while busy
// All outputs are flops or state decode; no input reaches an output.
// ---------------------------------------------------------------------------
module sc_bitstream_serializer
  import sc_pkg::*;
#(
  parameter int SC_LENGTH  = 1024,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  output logic                  sc_en_o,
  output logic                  sc_data_o,
  output logic                  sc_clear_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int LEN_CNT_W = sc_clog2(SC_LENGTH + 1);

  sc_state_t             r_state;
  sc_state_t             w_next;
  logic [LEN_CNT_W-1:0]  r_len_cnt;
  logic                  r_err;

  logic w_st_idle;
  logic w_st_clear;
  logic w_st_load;
  logic w_st_shift;
  logic w_st_done;
  logic w_bit;
  logic w_last_word;
  logic w_last_load;
  logic w_accept;

  assign w_st_idle  = (r_state == ST_IDLE);
  assign w_st_clear = (r_state == ST_CLEAR);
  assign w_st_load  = (r_state == ST_LOAD);
  assign w_st_shift = (r_state == ST_SHIFT);
  assign w_st_done  = (r_state == ST_DONE);

  assign w_last_load = w_st_shift && (r_len_cnt == LEN_CNT_W'(SC_LENGTH - 1));

  // Ready on the last bit of a word lets the next word follow without a gap.
  // Never ready on the last bit of the load, which caps the words per load
  // at ceil(SC_LENGTH/WORD_WIDTH).
  assign word_ready_o = w_st_load || (w_st_shift && w_last_word && !w_last_load);
  assign w_accept     = word_valid_i && word_ready_o;

  sc_piso_word #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_accept),
    .shift_i (w_st_shift),
    .word_i  (word_i),
    .bit_o   (w_bit),
    .last_o  (w_last_word)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_LOAD;
      ST_LOAD:  if (w_accept) w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_last_load)                  w_next = ST_DONE;
        else if (w_last_word && !w_accept) w_next = ST_LOAD;
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    // Abort beats everything, including completion in the same cycle.
    if (abort_i && !w_st_idle) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_len_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= start_i && !w_st_idle;
      if (w_st_idle && start_i)
        r_len_cnt <= '0;
      else if (w_st_shift)
        r_len_cnt <= r_len_cnt + LEN_CNT_W'(1);
    end
  end

  assign sc_en_o    = w_st_shift;
  // Gated so the data line sits at 0 outside of shifting.
  assign sc_data_o  = w_st_shift && w_bit;
  assign sc_clear_o = !w_st_clear;
  assign busy_o     = !w_st_idle;
  assign done_o     = w_st_done;
  assign err_o      = r_err;

endmodule

// File: tb/tb_sc_bitstream_serializer.sv
module tb_sc_bitstream_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: SC_LENGTH=10, WORD_WIDTH=4
  logic       a_start, a_abort, a_valid;
  logic [3:0] a_word;
  logic       a_ready, a_en, a_data, a_clr, a_busy, a_done, a_err;
  // DUT B: SC_LENGTH=8, WORD_WIDTH=4
  logic       b_start, b_abort, b_valid;
  logic [3:0] b_word;
  logic       b_ready, b_en, b_data, b_clr, b_busy, b_done, b_err;

  sc_bitstream_serializer #(.SC_LENGTH(10), .WORD_WIDTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .abort_i(a_abort),
    .word_i(a_word), .word_valid_i(a_valid), .word_ready_o(a_ready),
    .sc_en_o(a_en), .sc_data_o(a_data), .sc_clear_o(a_clr),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err));

  sc_bitstream_serializer #(.SC_LENGTH(8), .WORD_WIDTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .abort_i(b_abort),
    .word_i(b_word), .word_valid_i(b_valid), .word_ready_o(b_ready),
    .sc_en_o(b_en), .sc_data_o(b_data), .sc_clear_o(b_clr),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err));

  int checks = 0;
  int errors = 0;

  // Scenario state / scan-chain model
  int         sel;
  int         cur_L;
  logic [3:0] words[$];
  logic       stream[$];
  logic [9:0] chain_m;
  int widx, acc, gap_left, stall_n, start_at, abort_at;
  bit rnd_gap, start_req;
  int cyc, clr_cnt, clr_cyc, en_cnt, first_en, last_en;
  int done_cnt, done_cyc, err_cnt, abort_cyc, rdy_after;
  logic post_en, post_busy;

  // Expected chain bit i: word i/4, bit i%4 (first shifted bit ends at 0).
  function automatic logic exp_bit(int i);
    logic [3:0] w;
    w = words[i / 4];
    return w[i % 4];
  endfunction

  function automatic logic [9:0] exp_chain();
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < cur_L; i++) r[i] = exp_bit(i);
    return r;
  endfunction

  function automatic bit stream_ok();
    if (stream.size() != cur_L) return 1'b0;
    for (int i = 0; i < cur_L; i++)
      if (stream[i] !== exp_bit(i)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_stats();
    stream.delete();
    widx = 0; acc = 0; gap_left = 0; cyc = 0;
    clr_cnt = 0; clr_cyc = -100; en_cnt = 0; first_en = -100; last_en = -100;
    done_cnt = 0; done_cyc = -100; err_cnt = 0; abort_cyc = -100; rdy_after = 0;
    post_en = 1'bx; post_busy = 1'bx; start_req = 1'b0;
  endtask

  // One clock: observe outputs at negedge, update model, drive next inputs.
  task automatic step();
    logic en, dat, clr, rdy, dn, er, bsy, vld, st, ab;
    logic [3:0] wd;
    @(negedge clk);
    cyc++;
    if (sel == 0) begin
      en = a_en; dat = a_data; clr = a_clr; rdy = a_ready; dn = a_done; er = a_err; bsy = a_busy;
    end else begin
      en = b_en; dat = b_data; clr = b_clr; rdy = b_ready; dn = b_done; er = b_err; bsy = b_busy;
    end
    if (cyc == abort_cyc + 1) begin post_en = en; post_busy = bsy; end
    if (abort_cyc > 0 && cyc > abort_cyc && rdy) rdy_after++;
    if (!clr) begin
      chain_m = '0; clr_cnt++; clr_cyc = cyc;
    end else if (en) begin
      chain_m = (chain_m >> 1) | (10'(dat) << (cur_L - 1));
      stream.push_back(dat);
      if (en_cnt == 0) first_en = cyc;
      last_en = cyc;
      en_cnt++;
    end
    if (dn) begin done_cnt++; done_cyc = cyc; end
    if (er) err_cnt++;
    ab = (abort_at > 0 && en && en_cnt == abort_at && abort_cyc < 0);
    if (ab) abort_cyc = cyc;
    if (start_at > 0 && en && en_cnt == start_at) start_req = 1'b1;
    st = start_req;
    start_req = 1'b0;
    vld = 1'b0;
    if (widx < words.size()) begin
      if (rdy && gap_left > 0) gap_left--;
      else vld = rnd_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    wd = (widx < words.size()) ? words[widx] : 4'($urandom);
    if (vld && rdy) begin
      widx++; acc++;
      if (acc == 1) gap_left = stall_n;
    end
    if (sel == 0) begin
      a_start = st; a_abort = ab; a_valid = vld; a_word = wd;
    end else begin
      b_start = st; b_abort = ab; b_valid = vld; b_word = wd;
    end
  endtask

  task automatic run_load(int bound);
    bit fin;
    fin = 1'b0;
    clear_stats();
    start_req = 1'b1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done_cnt > 0 || (abort_cyc > 0 && cyc >= abort_cyc + 6)) begin fin = 1'b1; break; end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL load_timeout: no completion within %0d cycles (en_cnt=%0d)", bound, en_cnt);
    end
    step(); step();
  endtask

  task automatic setup(int s, int len, int stall, bit rg, int st_at, int ab_at);
    sel = s; cur_L = len; stall_n = stall; rnd_gap = rg; start_at = st_at; abort_at = ab_at;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_valid = 0; a_word = 0;
    b_start = 0; b_abort = 0; b_valid = 0; b_word = 0;
    chain_m = '0;
    #3;
    checks++;
    if ({a_en, a_data, a_clr, a_ready, a_busy, a_done, a_err} !== 7'b0010000) begin
      errors++; $display("FAIL reset_a: got %b want 0010000",
        {a_en, a_data, a_clr, a_ready, a_busy, a_done, a_err});
    end
    checks++;
    if ({b_en, b_data, b_clr, b_ready, b_busy, b_done, b_err} !== 7'b0010000) begin
      errors++; $display("FAIL reset_b: got %b want 0010000",
        {b_en, b_data, b_clr, b_ready, b_busy, b_done, b_err});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_gapless();
    setup(0, 10, 0, 0, 0, 0);
    words = '{4'h5, 4'hA, 4'hF};
    run_load(60);
    checks++;
    if (!stream_ok()) begin errors++; $display("FAIL gapless_stream: %0d bits, want 1010010111", stream.size()); end
    checks++;
    if (chain_m !== 10'b1110100101) begin errors++; $display("FAIL gapless_chain: got %b want 1110100101", chain_m); end
    checks++;
    if (clr_cnt != 1 || first_en != clr_cyc + 2) begin
      errors++; $display("FAIL gapless_clear: clr_cnt=%0d first_en-clr=%0d want 1,2", clr_cnt, first_en - clr_cyc);
    end
    checks++;
    if (en_cnt != 10 || last_en - first_en != 9) begin
      errors++; $display("FAIL gapless_en: en=%0d span=%0d want 10,10", en_cnt, last_en - first_en + 1);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_en + 1) begin
      errors++; $display("FAIL gapless_done: cnt=%0d delay=%0d want 1,1", done_cnt, done_cyc - last_en);
    end
    checks++;
    if (acc != 3 || err_cnt != 0) begin errors++; $display("FAIL gapless_words: acc=%0d err=%0d want 3,0", acc, err_cnt); end
  endtask

  task automatic test_stall();
    setup(0, 10, 3, 0, 0, 0);
    words = '{4'h5, 4'hA, 4'hF};
    run_load(80);
    checks++;
    if (!stream_ok() || chain_m !== 10'b1110100101) begin
      errors++; $display("FAIL stall_chain: got %b want 1110100101 (bits=%0d)", chain_m, stream.size());
    end
    checks++;
    if (en_cnt != 10 || last_en - first_en + 1 != 13) begin
      errors++; $display("FAIL stall_en: en=%0d span=%0d want 10,13", en_cnt, last_en - first_en + 1);
    end
    checks++;
    if (acc != 3 || done_cnt != 1) begin errors++; $display("FAIL stall_words: acc=%0d done=%0d want 3,1", acc, done_cnt); end
  endtask

  task automatic test_abort();
    setup(0, 10, 0, 0, 0, 5);
    words = '{4'($urandom), 4'($urandom), 4'($urandom)};
    run_load(60);
    checks++;
    if (en_cnt != 5 || post_en !== 1'b0 || post_busy !== 1'b0) begin
      errors++; $display("FAIL abort_stop: en=%0d post_en=%b post_busy=%b want 5,0,0", en_cnt, post_en, post_busy);
    end
    checks++;
    if (done_cnt != 0 || rdy_after != 0) begin
      errors++; $display("FAIL abort_quiet: done=%0d ready_cycles=%0d want 0,0", done_cnt, rdy_after);
    end
    abort_at = 0;
  endtask

  task automatic test_start_during_shift();
    setup(0, 10, 0, 0, 3, 0);
    words = '{4'h5, 4'hA, 4'hF};
    run_load(60);
    checks++;
    if (err_cnt != 1) begin errors++; $display("FAIL busy_start_err: pulses=%0d want 1", err_cnt); end
    checks++;
    if (!stream_ok() || chain_m !== 10'b1110100101 || en_cnt != 10 || acc != 3 || done_cnt != 1) begin
      errors++; $display("FAIL busy_start_load: chain=%b en=%0d acc=%0d done=%0d want 1110100101,10,3,1",
        chain_m, en_cnt, acc, done_cnt);
    end
    start_at = 0;
  endtask

  task automatic test_reset_mid_shift();
    setup(0, 10, 0, 0, 0, 0);
    words = '{4'($urandom), 4'($urandom), 4'($urandom)};
    clear_stats();
    start_req = 1'b1;
    for (int i = 0; i < 40 && en_cnt < 6; i++) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_en, a_data, a_clr, a_ready, a_busy, a_done, a_err} !== 7'b0010000) begin
      errors++; $display("FAIL async_reset: got %b want 0010000 (en_cnt=%0d)",
        {a_en, a_data, a_clr, a_ready, a_busy, a_done, a_err}, en_cnt);
    end
    a_start = 0; a_abort = 0; a_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    words = '{4'($urandom), 4'($urandom), 4'($urandom)};
    run_load(60);
    checks++;
    if (clr_cnt != 1 || !stream_ok() || chain_m !== exp_chain() || done_cnt != 1) begin
      errors++; $display("FAIL reset_reload: chain=%b want %b clr=%0d done=%0d", chain_m, exp_chain(), clr_cnt, done_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      setup(0, 10, 0, 1, 0, 0);
      words = '{4'($urandom), 4'($urandom), 4'($urandom)};
      run_load(120);
      checks++;
      if (!stream_ok() || chain_m !== exp_chain() || en_cnt != 10 || acc != 3 || done_cnt != 1 || err_cnt != 0) begin
        errors++; $display("FAIL random_%0d: chain=%b want %b en=%0d acc=%0d done=%0d err=%0d",
          n, chain_m, exp_chain(), en_cnt, acc, done_cnt, err_cnt);
      end
    end
  endtask

  task automatic test_exact_multiple();
    setup(1, 8, 0, 0, 0, 0);
    chain_m = '0;
    words = '{4'h3, 4'hC};
    run_load(60);
    checks++;
    if (chain_m[7:0] !== 8'hC3 || !stream_ok()) begin
      errors++; $display("FAIL exact_chain: got %h want c3", chain_m[7:0]);
    end
    checks++;
    if (acc != 2 || en_cnt != 8 || last_en - first_en != 7 || done_cyc != last_en + 1 || done_cnt != 1) begin
      errors++; $display("FAIL exact_timing: acc=%0d en=%0d span=%0d done_delay=%0d want 2,8,8,1",
        acc, en_cnt, last_en - first_en + 1, done_cyc - last_en);
    end
    setup(1, 8, 0, 1, 0, 0);
    words = '{4'($urandom), 4'($urandom)};
    run_load(100);
    checks++;
    if (chain_m !== exp_chain() || !stream_ok() || acc != 2 || done_cnt != 1) begin
      errors++; $display("FAIL exact_random: chain=%b want %b acc=%0d", chain_m, exp_chain(), acc);
    end
  endtask

  initial begin
    sel = 0; cur_L = 10; stall_n = 0; rnd_gap = 0; start_at = 0; abort_at = 0;
    test_reset();
    test_gapless();
    test_stall();
    test_abort();
    test_start_during_shift();
    test_reset_mid_shift();
    test_random();
    test_exact_multiple();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
